// File: rtl/iref_bank_seq.sv
// Multi-channel bias-reference sequencer: per-channel power-up, calibration, settle and ready,
// with one calibration engine shared between channels through a round-robin arbiter.
module iref_bank_seq #(
   parameter int unsigned N_CH     = 4,
   parameter int unsigned CLK_MHZ  = 5,
   parameter int unsigned T_CAL_US = 5,
   parameter int unsigned T_RDY_US = 2,
   parameter int unsigned T_TO_US  = 20,
   parameter int unsigned CW       = 16
) (
   input  logic            CLK,
   input  logic            RST_N,
   input  logic [N_CH-1:0] PU,
   input  logic [N_CH-1:0] CAL,
   output logic [N_CH-1:0] RDY,
   output logic [N_CH-1:0] CAL_GNT,
   output logic [N_CH-1:0] ERR,
   output logic            BUSY
);

   localparam int unsigned PW = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam logic [CW-1:0] CalCyc = CW'(T_CAL_US * CLK_MHZ);
   localparam logic [CW-1:0] RdyCyc = CW'(T_RDY_US * CLK_MHZ);
   localparam logic [CW-1:0] ToCyc  = CW'(T_TO_US * CLK_MHZ);

   typedef enum logic [2:0] {
      StOff,
      StWait,
      StCalib,
      StSettle,
      StReady,
      StFault
   } state_e;

   state_e          st_q   [N_CH];
   state_e          st_d   [N_CH];
   logic [CW-1:0]   cnt_q  [N_CH];
   logic [CW-1:0]   cnt_d  [N_CH];
   logic [CW-1:0]   to_q   [N_CH];
   logic [CW-1:0]   to_d   [N_CH];
   logic [PW-1:0]   ptr_q, ptr_d;
   logic            first_q, first_d;
   logic [N_CH-1:0] rdy_q, rdy_d;
   logic [N_CH-1:0] gnt_q, gnt_d;
   logic [N_CH-1:0] err_q, err_d;

   logic            any_cal;
   logic            found;
   logic            grant_en;
   logic [PW-1:0]   gnt_idx;
   int unsigned     arb_start;
   int unsigned     arb_j;

   // Arbiter: search starts at channel 0 until the first grant after reset, then at pointer+1.
   always_comb begin
      any_cal   = 1'b0;
      found     = 1'b0;
      gnt_idx   = '0;
      arb_j     = 0;
      arb_start = first_q ? 0 : ((int'(ptr_q) + 1) % N_CH);
      for (int i = 0; i < N_CH; i++) begin
         if (st_q[i] == StCalib) any_cal = 1'b1;
      end
      for (int k = 0; k < N_CH; k++) begin
         arb_j = (arb_start + k) % N_CH;
         if (!found && st_q[arb_j] == StWait && PU[arb_j]) begin
            found   = 1'b1;
            gnt_idx = PW'(arb_j);
         end
      end
      // Gating on the registered CALIB state leaves one idle engine cycle between grants.
      grant_en = found && !any_cal;
      ptr_d    = grant_en ? gnt_idx : ptr_q;
      first_d  = grant_en ? 1'b0 : first_q;
   end

   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         st_d[i]  = st_q[i];
         cnt_d[i] = cnt_q[i];
         to_d[i]  = to_q[i];
         if (!PU[i]) begin
            st_d[i]  = StOff;
            cnt_d[i] = '0;
            to_d[i]  = '0;
         end else begin
            unique case (st_q[i])
               StOff: st_d[i] = StWait;
               StWait: begin
                  if (grant_en && gnt_idx == PW'(i)) begin
                     st_d[i]  = StCalib;
                     cnt_d[i] = CalCyc;
                     to_d[i]  = ToCyc;
                  end
               end
               StCalib: begin
                  to_d[i] = to_q[i] - 1'b1;
                  if (CAL[i]) cnt_d[i] = cnt_q[i] - 1'b1;
                  // Completion beats timeout when both expire on the same edge.
                  if (CAL[i] && cnt_q[i] == CW'(1)) begin
                     st_d[i]  = StSettle;
                     cnt_d[i] = RdyCyc;
                     to_d[i]  = '0;
                  end else if (to_q[i] == CW'(1)) begin
                     st_d[i]  = StFault;
                     cnt_d[i] = '0;
                  end
               end
               StSettle: begin
                  cnt_d[i] = cnt_q[i] - 1'b1;
                  if (cnt_q[i] == CW'(1)) st_d[i] = StReady;
               end
               StReady: st_d[i] = StReady;
               StFault: st_d[i] = StFault;
               default: st_d[i] = StOff;
            endcase
         end
      end
   end

   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         rdy_d[i] = (st_d[i] == StReady);
         gnt_d[i] = (st_d[i] == StCalib);
         err_d[i] = (st_d[i] == StFault);
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < N_CH; i++) begin
            st_q[i]  <= StOff;
            cnt_q[i] <= '0;
            to_q[i]  <= '0;
         end
         ptr_q   <= '0;
         first_q <= 1'b1;
         rdy_q   <= '0;
         gnt_q   <= '0;
         err_q   <= '0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            st_q[i]  <= st_d[i];
            cnt_q[i] <= cnt_d[i];
            to_q[i]  <= to_d[i];
         end
         ptr_q   <= ptr_d;
         first_q <= first_d;
         rdy_q   <= rdy_d;
         gnt_q   <= gnt_d;
         err_q   <= err_d;
      end
   end

   assign RDY     = rdy_q;
   assign CAL_GNT = gnt_q;
   assign ERR     = err_q;
   assign BUSY    = |gnt_q;

endmodule

// File: tb/tb_iref_bank_seq.sv
// Directed self-checking bench for iref_bank_seq with default parameters.
module tb_iref_bank_seq;

   logic       clk;
   logic       rst_n;
   logic [3:0] pu;
   logic [3:0] cal;
   logic [3:0] rdy;
   logic [3:0] gnt;
   logic [3:0] err;
   logic       busy;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = -1;

   iref_bank_seq dut (
      .CLK     (clk),
      .RST_N   (rst_n),
      .PU      (pu),
      .CAL     (cal),
      .RDY     (rdy),
      .CAL_GNT (gnt),
      .ERR     (err),
      .BUSY    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h (cycle E%0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic go_to(input int e);
      while (cyc < e) tick();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      pu    = '0;
      cal   = '0;
      #3;
      rst_n = 1'b1;
      cyc   = -1;
   endtask

   initial begin
      rst_n = 1'b0;
      pu    = '0;
      cal   = '0;
      #12;
      check("reset_rdy", rdy, 0);
      check("reset_gnt", gnt, 0);
      check("reset_err", err, 0);
      check("reset_busy", busy, 0);
      rst_n = 1'b1;
      tick();

      // Single channel, CAL held high.
      cyc = -1;
      pu  = 4'b0001;
      cal = 4'b0001;
      go_to(0);  check("s1_e0_gnt", gnt, 0);
      go_to(1);  check("s1_e1_gnt", gnt, 4'b0001); check("s1_e1_busy", busy, 1);
      go_to(25); check("s1_e25_gnt", gnt, 4'b0001);
      go_to(26); check("s1_e26_gnt", gnt, 0);
      go_to(35); check("s1_e35_rdy", rdy, 0);
      go_to(36); check("s1_e36_rdy", rdy, 4'b0001); check("s1_err", err, 0);
      pu = '0;
      tick();    check("s1_pu_off_rdy", rdy, 0);
      tick();

      // CAL toggling: qualifying edges are odd cycles from E3.
      cyc = -1;
      pu  = 4'b0001;
      for (int k = 0; k <= 61; k++) begin
         cal = {3'b000, k[0]};
         tick();
         if (k == 50) check("s2_e50_gnt", gnt, 4'b0001);
         if (k == 51) check("s2_e51_gnt", gnt, 0);
         if (k == 60) check("s2_e60_rdy", rdy, 0);
         if (k == 61) check("s2_e61_rdy", rdy, 4'b0001);
      end
      pu  = '0;
      cal = '0;
      tick();
      tick();

      // Timeout on channel 2.
      cyc = -1;
      pu  = 4'b0100;
      go_to(1);   check("s3_e1_gnt", gnt, 4'b0100);
      go_to(100); check("s3_e100_err", err, 0); check("s3_e100_gnt", gnt, 4'b0100);
      go_to(101); check("s3_e101_err", err, 4'b0100); check("s3_e101_gnt", gnt, 0);
      check("s3_e101_rdy", rdy, 0);
      pu = '0;
      tick();     check("s3_err_clear", err, 0);

      // All four channels together: round-robin order 0,1,2,3.
      do_reset();
      pu  = 4'b1111;
      cal = 4'b1111;
      while (cyc < 114) begin
         tick();
         check("s4_onehot", {31'd0, $onehot0(gnt)}, 1);
         if (cyc == 1)   check("s4_e1_gnt", gnt, 4'b0001);
         if (cyc == 26)  check("s4_e26_gnt", gnt, 0);
         if (cyc == 27)  check("s4_e27_gnt", gnt, 4'b0010);
         if (cyc == 53)  check("s4_e53_gnt", gnt, 4'b0100);
         if (cyc == 79)  check("s4_e79_gnt", gnt, 4'b1000);
         if (cyc == 113) check("s4_e113_rdy", rdy, 4'b0111);
         if (cyc == 114) check("s4_e114_rdy", rdy, 4'b1111);
      end

      // Drop PU[1] mid-calibration, then re-raise it.
      do_reset();
      pu  = 4'b0110;
      cal = 4'b1111;
      go_to(1);  check("s5_e1_gnt", gnt, 4'b0010);
      go_to(10);
      pu[1] = 1'b0;
      go_to(11); check("s5_e11_gnt", gnt, 0); check("s5_e11_rdy", rdy, 0);
      go_to(12); check("s5_e12_gnt", gnt, 4'b0100);
      pu[1] = 1'b1;
      go_to(37); check("s5_e37_gnt", gnt, 0);
      go_to(38); check("s5_e38_gnt", gnt, 4'b0010);
      go_to(47); check("s5_e47_rdy", rdy, 4'b0100);
      go_to(62); check("s5_e62_gnt", gnt, 4'b0010);
      go_to(63); check("s5_e63_gnt", gnt, 0);
      go_to(72); check("s5_e72_rdy", rdy, 4'b0100);
      go_to(73); check("s5_e73_rdy", rdy, 4'b0110);

      // Asynchronous reset with ch0 READY and ch1 SETTLE.
      do_reset();
      pu  = 4'b0011;
      cal = 4'b0011;
      go_to(55); check("s6_pre_rdy", rdy, 4'b0001); check("s6_pre_gnt", gnt, 0);
      #2;
      rst_n = 1'b0;
      #1;
      check("s6_async_rdy", rdy, 0);
      check("s6_async_gnt", gnt, 0);
      check("s6_async_busy", busy, 0);
      rst_n = 1'b1;
      cyc   = -1;
      go_to(0);  check("s6_e0_gnt", gnt, 0); check("s6_e0_rdy", rdy, 0);
      go_to(1);  check("s6_e1_gnt", gnt, 4'b0001);
      go_to(35); check("s6_e35_rdy", rdy, 0);
      go_to(36); check("s6_e36_rdy", rdy, 4'b0001);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
